regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//  Writeback stage feeding the register-file write port (rd / rd_value / wr_en).
//  Accepts results from two producers (src0 = ALU, src1 = load/store unit) over
//  valid/ready, buffers each in its own small FIFO, and round-robin serialises them
//  onto the single write port, one write per clk. Writes to x0 are accepted and dropped.
//  Outputs are registered on posedge clk so they are stable at the register file's negedge write.
// PARAMETERS
//  REG_COUNT   32  number of architectural registers; rd width = $clog2(REG_COUNT)
//  REG_WIDTH   32  data width of one register
//  FIFO_DEPTH  2   entries per source FIFO (power of two, >= 2)
// PORTS
//  clk            in   1          single clock; all state updates on posedge
//  reset          in   1          asynchronous, active-high
//  src0_valid     in   1          ALU result valid
//  src0_ready     out  1          src0 FIFO can accept (not full)
//  src0_rd        in   RA         destination register, RA = $clog2(REG_COUNT)
//  src0_value     in   REG_WIDTH  result value
//  src1_valid/src1_ready/src1_rd/src1_value   same as src0, for load/store unit
//  rd             out  RA         register-file write index
//  rd_value       out  REG_WIDTH  register-file write data
//  wr_en          out  1          register-file write enable (one-cycle pulse per write)
//  pending        out  REG_COUNT  bit i set while any buffered entry targets reg i (i != 0)
//  busy           out  1          any FIFO non-empty or wr_en high
// BEHAVIOUR
//  - Reset (async): both FIFOs empty, rr pointer = src0, rd = 0, rd_value = 0, wr_en = 0,
//    pending = 0, busy = 0; srcN_ready = 1 once reset deasserts. Reset mid-stream discards all entries.
//  - Accept: srcN_valid & srcN_ready at posedge k pushes {rd,value}; srcN_ready = !full, from
//    registered count only (no combinational path from valid to ready).
//  - Source must hold valid/rd/value stable until accepted.
//  - Arbitration (combinational from FIFO heads, registered result): if exactly one FIFO non-empty,
//    grant it; if both, grant the rr-pointer source, then pointer moves to the other source.
//    Pointer unchanged on idle cycles or single-source grants to the pointer source; single grant
//    to the non-pointer source moves pointer away from it.
//  - Grant at posedge k+1 pops that head and loads rd/rd_value; wr_en = 1 for cycle k+1..k+2 iff
//    popped rd != 0, else wr_en = 0 (entry consumed, grant slot used). Accept-to-wr_en latency = 1 cycle.
//  - No grant: wr_en = 0; rd/rd_value hold last value.
//  - Full FIFO: ready = 0; a pop on that edge raises ready the next cycle (no same-edge push-through).
//  - Push and pop same edge on non-full FIFO: count unchanged, order preserved.
//  - Ordering: FIFO order within a source; no ordering across sources (upstream guarantees no
//    same-rd WAW across sources in flight).
//  - pending: OR over valid FIFO entries of onehot(rd), bit 0 forced 0; combinational from state.
//  - Peak throughput 1 write/cycle total; steady state both sources alternate 1 write each per 2 cycles.
// STRUCTURE
//  - processor_pkg: NUM_WB_SRC = 2, typedef wb_req_t {logic [RA-1:0] rd; logic [REG_WIDTH-1:0] value;}
//    (package parameterised via module-level params passed to typedef widths).
//  - Sub-module wb_fifo (one instance per source): depth FIFO_DEPTH, push/pop, full/empty,
//    head, per-entry valid vector exported for pending.
//  - Top: two wb_fifo, 1-bit rr pointer, output register stage.
// TESTING
//  1. Reset, src0 pushes {rd=5,0xDEADBEEF} at edge 1 -> edge 2: wr_en=1, rd=5, rd_value=0xDEADBEEF; edge 3: wr_en=0.
//  2. Both valid every cycle, src0 rd=1..4, src1 rd=11..14 -> writes 1,11,2,12,3,13,4,14 in order, no gaps.
//  3. src1 push rd=0 value=0x1234 -> consumed, wr_en stays 0 for whole test, pending stays 0.
//  4. Hold output stall impossible; instead push 3 to src0 with src1 saturating: src0_ready drops after
//     2 accepts (FIFO_DEPTH=2), rises next cycle after a src0 pop; all 3 writes appear.
//  5. Push rd=7 and rd=9 into src0 then assert reset async mid-cycle -> outputs 0 immediately,
//     pending=0, no later wr_en for 7 or 9.
//  6. pending: push rd=3 -> pending[3]=1 next cycle; clears on cycle its wr_en rises.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared writeback definitions: source count and round-robin pointer encoding.
package processor_pkg;
    localparam int NUM_WB_SRC = 2;

    typedef enum logic {
        RR_SRC0 = 1'b0,
        RR_SRC1 = 1'b1
    } rr_sel_e;
endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// Per-source writeback FIFO; exports per-entry valid bits and the rd tag of every entry.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int TAG_W = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                din,
    output logic                        full,
    output logic                        empty,
    output logic [W-1:0]                head,
    output logic [DEPTH-1:0]            ent_vld,
    output logic [DEPTH-1:0][TAG_W-1:0] ent_tag
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wptr, rptr;
    logic [PW:0]             count;
    logic                    do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Tag is the leading field of the entry, so it sits in the MSBs.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent_tag[i] = mem[i][W-1 -: TAG_W];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (do_push) begin
                wptr          <= wptr + PW'(1);
                ent_vld[wptr] <= 1'b1;
            end
            if (do_pop) begin
                rptr          <= rptr + PW'(1);
                ent_vld[rptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: two buffered producers round-robin serialised onto one
// registered register-file write port.
module regfile_writeback_arbiter
    import processor_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int RA        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src0_valid,
    output logic                 src0_ready,
    input  logic [RA-1:0]        src0_rd,
    input  logic [REG_WIDTH-1:0] src0_value,
    input  logic                 src1_valid,
    output logic                 src1_ready,
    input  logic [RA-1:0]        src1_rd,
    input  logic [REG_WIDTH-1:0] src1_value,
    output logic [RA-1:0]        rd,
    output logic [REG_WIDTH-1:0] rd_value,
    output logic                 wr_en,
    output logic [REG_COUNT-1:0] pending,
    output logic                 busy
);
    typedef struct packed {
        logic [RA-1:0]        rd;
        logic [REG_WIDTH-1:0] value;
    } wb_req_t;

    localparam int W = $bits(wb_req_t);

    wb_req_t [NUM_WB_SRC-1:0]                      req_in;
    logic    [NUM_WB_SRC-1:0][W-1:0]               head;
    logic    [NUM_WB_SRC-1:0]                      valid_in, push, grant, full, empty;
    logic    [NUM_WB_SRC-1:0][FIFO_DEPTH-1:0]      ent_vld;
    logic    [NUM_WB_SRC-1:0][FIFO_DEPTH-1:0][RA-1:0] ent_tag;
    wb_req_t                                       win;
    rr_sel_e                                       rr;

    assign valid_in   = {src1_valid, src0_valid};
    assign req_in[0]  = '{rd: src0_rd, value: src0_value};
    assign req_in[1]  = '{rd: src1_rd, value: src1_value};
    assign src0_ready = ~full[0];
    assign src1_ready = ~full[1];
    assign push       = valid_in & ~full;

    for (genvar s = 0; s < NUM_WB_SRC; s++) begin : g_src
        wb_fifo #(.DEPTH(FIFO_DEPTH), .W(W), .TAG_W(RA)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push    (push[s]),
            .pop     (grant[s]),
            .din     (req_in[s]),
            .full    (full[s]),
            .empty   (empty[s]),
            .head    (head[s]),
            .ent_vld (ent_vld[s]),
            .ent_tag (ent_tag[s])
        );
    end

    // The pointer only decides contention; single-source grants leave it alone.
    always_comb begin
        grant = '0;
        if (!empty[0] && (empty[1] || rr == RR_SRC0)) grant[0] = 1'b1;
        else if (!empty[1])                           grant[1] = 1'b1;
        win = grant[1] ? wb_req_t'(head[1]) : wb_req_t'(head[0]);
    end

    always_comb begin
        pending = '0;
        for (int s = 0; s < NUM_WB_SRC; s++)
            for (int e = 0; e < FIFO_DEPTH; e++)
                if (ent_vld[s][e]) pending[ent_tag[s][e]] = 1'b1;
        pending[0] = 1'b0;
    end

    assign busy = ~(&empty) | wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr       <= RR_SRC0;
            rd       <= '0;
            rd_value <= '0;
            wr_en    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (|grant) begin
                rd       <= win.rd;
                rd_value <= win.value;
                wr_en    <= (win.rd != '0);
            end
            if (!empty[0] && !empty[1])
                rr <= (rr == RR_SRC0) ? RR_SRC1 : RR_SRC0;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with hand-computed expectations.
module tb_regfile_writeback_arbiter;
    localparam int RA = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          src0_valid = 1'b0, src1_valid = 1'b0;
    logic          src0_ready, src1_ready;
    logic [RA-1:0] src0_rd = '0, src1_rd = '0;
    logic [31:0]   src0_value = '0, src1_value = '0;
    logic [RA-1:0] rd;
    logic [31:0]   rd_value;
    logic          wr_en;
    logic [31:0]   pending;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int wr_q[$];
    bit rdy0_hist[$];
    bit wen_hist[$];

    regfile_writeback_arbiter dut (
        .clk(clk), .reset(reset),
        .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rd(src0_rd), .src0_value(src0_value),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rd(src1_rd), .src1_value(src1_value),
        .rd(rd), .rd_value(rd_value), .wr_en(wr_en), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        src0_valid = 1'b0; src1_valid = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Producers hold each item until accepted; writes and ready history are recorded per cycle.
    task automatic run_stream(input int n0, input int b0, input int n1, input int b1, input int ncyc);
        int  i0 = 0, i1 = 0;
        bit  acc0, acc1;
        wr_q.delete(); rdy0_hist.delete(); wen_hist.delete();
        for (int c = 0; c < ncyc; c++) begin
            src0_valid = (i0 < n0); src0_rd = RA'(b0 + i0); src0_value = 32'hA000_0000 | 32'(b0 + i0);
            src1_valid = (i1 < n1); src1_rd = RA'(b1 + i1); src1_value = 32'hA000_0000 | 32'(b1 + i1);
            acc0 = src0_valid && src0_ready;
            acc1 = src1_valid && src1_ready;
            tick();
            if (acc0) i0++;
            if (acc1) i1++;
            rdy0_hist.push_back(src0_ready);
            wen_hist.push_back(wr_en);
            if (wr_en) begin
                wr_q.push_back(int'(rd));
                chk("stream_value", rd_value, 32'hA000_0000 | 32'(rd));
            end
        end
        src0_valid = 1'b0; src1_valid = 1'b0;
    endtask

    initial begin
        int exp2[8];
        int exp4[11];
        bit seen;

        // Reset state
        tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rd_value", rd_value, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        chk("rst_ready0", src0_ready, 1);
        chk("rst_ready1", src1_ready, 1);

        // Test 1: single write, latency one cycle
        src0_valid = 1'b1; src0_rd = 5; src0_value = 32'hDEADBEEF;
        tick();
        src0_valid = 1'b0;
        chk("t1_wr_en_e1", wr_en, 0);
        chk("t1_pending_e1", pending, 32'h0000_0020);
        chk("t1_busy_e1", busy, 1);
        tick();
        chk("t1_wr_en_e2", wr_en, 1);
        chk("t1_rd_e2", rd, 5);
        chk("t1_value_e2", rd_value, 32'hDEADBEEF);
        chk("t1_pending_e2", pending, 0);
        tick();
        chk("t1_wr_en_e3", wr_en, 0);
        chk("t1_rd_hold", rd, 5);
        chk("t1_busy_e3", busy, 0);

        // Test 2: both sources every cycle, strict alternation without gaps
        do_reset();
        exp2 = '{1, 11, 2, 12, 3, 13, 4, 14};
        run_stream(4, 1, 4, 11, 12);
        chk("t2_count", wr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++)
            chk($sformatf("t2_order_%0d", i), wr_q[i], exp2[i]);
        seen = 1'b1;
        for (int c = 1; c <= 8; c++) if (!wen_hist[c]) seen = 1'b0;
        chk("t2_no_gaps", seen, 1);

        // Test 3: write to x0 is consumed silently
        do_reset();
        src1_valid = 1'b1; src1_rd = 0; src1_value = 32'h1234;
        tick();
        src1_valid = 1'b0;
        chk("t3_pending_e1", pending, 0);
        chk("t3_busy_e1", busy, 1);
        chk("t3_wr_en_e1", wr_en, 0);
        tick();
        chk("t3_wr_en_e2", wr_en, 0);
        chk("t3_pending_e2", pending, 0);
        tick();
        chk("t3_wr_en_e3", wr_en, 0);
        chk("t3_busy_e3", busy, 0);

        // Test 4: src0 fills while src1 saturates; ready drops, then recovers after a pop
        do_reset();
        exp4 = '{6, 21, 7, 22, 8, 23, 24, 25, 26, 27, 28};
        run_stream(3, 6, 8, 21, 14);
        chk("t4_count", wr_q.size(), 11);
        for (int i = 0; i < 11 && i < wr_q.size(); i++)
            chk($sformatf("t4_order_%0d", i), wr_q[i], exp4[i]);
        chk("t4_ready0_e2", rdy0_hist[1], 1);
        chk("t4_ready0_full", rdy0_hist[2], 0);
        chk("t4_ready0_rise", rdy0_hist[3], 1);

        // Test 5: asynchronous reset mid-stream discards buffered work
        do_reset();
        src0_valid = 1'b1; src0_rd = 7; src0_value = 32'h7;
        tick();
        src0_rd = 9; src0_value = 32'h9;
        tick();
        src0_valid = 1'b0;
        chk("t5_wr_en_pre", wr_en, 1);
        chk("t5_rd_pre", rd, 7);
        chk("t5_pending_pre", pending, 32'h0000_0200);
        #2 reset = 1'b1;
        #1;
        chk("t5_wr_en_async", wr_en, 0);
        chk("t5_rd_async", rd, 0);
        chk("t5_value_async", rd_value, 0);
        chk("t5_pending_async", pending, 0);
        chk("t5_busy_async", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (wr_en) seen = 1'b1;
        end
        chk("t5_no_late_write", seen, 0);

        // Test 6: pending tracks a buffered entry until its write fires
        do_reset();
        src0_valid = 1'b1; src0_rd = 3; src0_value = 32'h33;
        tick();
        src0_valid = 1'b0;
        chk("t6_pending_set", pending, 32'h0000_0008);
        tick();
        chk("t6_wr_en", wr_en, 1);
        chk("t6_rd", rd, 3);
        chk("t6_pending_clr", pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
